// File: rtl/alu_op_decoder.sv
// Registered RV32 ALU-operation decoder: combinational decode into one pipeline register.
// Optional illegal-encoding detection is enabled with macro ALU_OP_DECODER_ILLEGAL_CHECK_EN.
module alu_op_decoder #(
  parameter int NB_INSTR = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NB_INSTR-1:0] i_instr,
  input  logic                i_valid,
  input  logic                i_stall,
  input  logic                i_flush,
  output logic [3:0]          o_alu_op,
  output logic                o_alu_src_imm,
  output logic                o_valid,
  output logic                o_illegal
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_SLL  = 4'b0010,
    OP_SLT  = 4'b0011,
    OP_SLTU = 4'b0100,
    OP_XOR  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_OR   = 4'b1000,
    OP_AND  = 4'b1001
  } alu_op_e;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       f7_alt;
  logic       unused_instr_bits;

  assign opcode = i_instr[6:0];
  assign funct3 = i_instr[14:12];
  assign funct7 = i_instr[31:25];
  assign f7_alt = (funct7 == 7'b0100000);
  // Register and immediate fields do not affect the ALU operation.
  assign unused_instr_bits = ^{i_instr[24:15], i_instr[11:7]};

  alu_op_e dec_op;
  logic    dec_imm;

  alu_op_e op_d, op_q;
  logic    imm_d, imm_q;
  logic    valid_d, valid_q;

`ifdef ALU_OP_DECODER_ILLEGAL_CHECK_EN
  logic dec_ill;
  logic illegal_d, illegal_q;
`endif

  always_comb begin
    dec_op  = OP_ADD;
    dec_imm = 1'b0;
`ifdef ALU_OP_DECODER_ILLEGAL_CHECK_EN
    dec_ill = 1'b0;
`endif
    case (opcode)
      OPC_RTYPE, OPC_ITYPE: begin
        dec_imm = (opcode == OPC_ITYPE);
        case (funct3)
          3'b000:  dec_op = (f7_alt && opcode == OPC_RTYPE) ? OP_SUB : OP_ADD;
          3'b001:  dec_op = OP_SLL;
          3'b010:  dec_op = OP_SLT;
          3'b011:  dec_op = OP_SLTU;
          3'b100:  dec_op = OP_XOR;
          3'b101:  dec_op = f7_alt ? OP_SRA : OP_SRL;
          3'b110:  dec_op = OP_OR;
          default: dec_op = OP_AND;
        endcase
`ifdef ALU_OP_DECODER_ILLEGAL_CHECK_EN
        if (opcode == OPC_RTYPE)
          dec_ill = (funct7 != '0) && !(f7_alt && (funct3 == 3'b000 || funct3 == 3'b101));
        else
          dec_ill = ((funct3 == 3'b001) && (funct7 != '0)) ||
                    ((funct3 == 3'b101) && (funct7 != '0) && !f7_alt);
`endif
      end
      OPC_LOAD, OPC_STORE, OPC_JALR, OPC_AUIPC, OPC_LUI, OPC_JAL: dec_imm = 1'b1;
      OPC_BRANCH: begin
        case (funct3)
          3'b000, 3'b001: dec_op = OP_SUB;
          3'b100, 3'b101: dec_op = OP_SLT;
          3'b110, 3'b111: dec_op = OP_SLTU;
          default: begin
`ifdef ALU_OP_DECODER_ILLEGAL_CHECK_EN
            dec_ill = 1'b1;
`endif
          end
        endcase
      end
      default: begin
`ifdef ALU_OP_DECODER_ILLEGAL_CHECK_EN
        dec_ill = 1'b1;
`endif
      end
    endcase
`ifdef ALU_OP_DECODER_ILLEGAL_CHECK_EN
    if (dec_ill) dec_op = OP_ADD;
`endif
  end

  // Flush beats stall; an idle (i_valid=0) load registers the same bubble as a flush.
  always_comb begin
    op_d    = op_q;
    imm_d   = imm_q;
    valid_d = valid_q;
`ifdef ALU_OP_DECODER_ILLEGAL_CHECK_EN
    illegal_d = illegal_q;
`endif
    if (i_flush || (!i_stall && !i_valid)) begin
      op_d    = OP_ADD;
      imm_d   = 1'b0;
      valid_d = 1'b0;
`ifdef ALU_OP_DECODER_ILLEGAL_CHECK_EN
      illegal_d = 1'b0;
`endif
    end else if (!i_stall) begin
      op_d    = dec_op;
      imm_d   = dec_imm;
      valid_d = 1'b1;
`ifdef ALU_OP_DECODER_ILLEGAL_CHECK_EN
      illegal_d = dec_ill;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q    <= OP_ADD;
      imm_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      op_q    <= op_d;
      imm_q   <= imm_d;
      valid_q <= valid_d;
    end
  end

`ifdef ALU_OP_DECODER_ILLEGAL_CHECK_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) illegal_q <= 1'b0;
    else          illegal_q <= illegal_d;
  end
  assign o_illegal = illegal_q;
`else
  assign o_illegal = 1'b0;
`endif

  assign o_alu_op      = op_q;
  assign o_alu_src_imm = imm_q;
  assign o_valid       = valid_q;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Bench for alu_op_decoder: directed scenarios followed by randomized traffic against a table-driven model.
module tb_alu_op_decoder;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] i_instr;
  logic        i_valid;
  logic        i_stall;
  logic        i_flush;
  logic [3:0]  o_alu_op;
  logic        o_alu_src_imm;
  logic        o_valid;
  logic        o_illegal;

  int compared;
  int mismatched;

  // Model of the output register
  logic [3:0] m_op;
  logic       m_imm;
  logic       m_valid;
  logic       m_ill;

  alu_op_decoder #(.NB_INSTR(32)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_instr       (i_instr),
    .i_valid       (i_valid),
    .i_stall       (i_stall),
    .i_flush       (i_flush),
    .o_alu_op      (o_alu_op),
    .o_alu_src_imm (o_alu_src_imm),
    .o_valid       (o_valid),
    .o_illegal     (o_illegal)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Op numbering: ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9.
  // The "alternate" form (SUB, SRA) is the base form plus one.
  function automatic void ref_decode(input logic [31:0] ins, output logic [3:0] op,
                                     output logic imm, output logic ill);
    int unsigned alu_tbl [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int unsigned br_tbl  [8] = '{1, 1, 0, 0, 3, 3, 4, 4};
    logic [6:0] opc = ins[6:0];
    logic [2:0] f3  = ins[14:12];
    logic [6:0] f7  = ins[31:25];
    int unsigned v  = 0;
    logic bad = 1'b0;
    imm = 1'b0;
    if (opc == 7'h33) begin
      v = alu_tbl[f3] + (((f3 == 3'd0 || f3 == 3'd5) && f7 == 7'h20) ? 1 : 0);
      bad = (f7 != 7'h00) && !(f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    end else if (opc == 7'h13) begin
      imm = 1'b1;
      v = alu_tbl[f3] + ((f3 == 3'd5 && f7 == 7'h20) ? 1 : 0);
      bad = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
    end else if (opc inside {7'h03, 7'h23, 7'h67, 7'h17, 7'h37, 7'h6F}) begin
      imm = 1'b1;
    end else if (opc == 7'h63) begin
      v = br_tbl[f3];
      bad = (f3 == 3'd2 || f3 == 3'd3);
    end else begin
      bad = 1'b1;
    end
`ifdef ALU_OP_DECODER_ILLEGAL_CHECK_EN
    ill = bad;
    if (bad) v = 0;
`else
    ill = 1'b0;
`endif
    op = v[3:0];
  endfunction

  // Apply one rising edge to the model, using the inputs that are present at the edge.
  function automatic void model_edge();
    logic [3:0] op;
    logic imm, ill;
    if (i_flush || (!i_stall && !i_valid)) begin
      m_op = 4'd0; m_imm = 1'b0; m_valid = 1'b0; m_ill = 1'b0;
    end else if (!i_stall) begin
      ref_decode(i_instr, op, imm, ill);
      m_op = op; m_imm = imm; m_valid = 1'b1; m_ill = ill;
    end
  endfunction

  function automatic void model_reset();
    m_op = 4'd0; m_imm = 1'b0; m_valid = 1'b0; m_ill = 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".op"},    o_alu_op,              m_op);
    chk({tag, ".imm"},   {3'b0, o_alu_src_imm}, {3'b0, m_imm});
    chk({tag, ".valid"}, {3'b0, o_valid},       {3'b0, m_valid});
    chk({tag, ".ill"},   {3'b0, o_illegal},     {3'b0, m_ill});
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic v, input logic s, input logic f);
    i_instr = ins; i_valid = v; i_stall = s; i_flush = f;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h67, 7'h17, 7'h37, 7'h6F, 7'h63, 7'h13};
    logic [31:0] ins = $urandom;
    int unsigned k = $urandom_range(0, 10);
    int unsigned s = $urandom_range(0, 2);
    if (k < 10) ins[6:0] = opcs[k];
    if (s == 0) ins[31:25] = 7'h00;
    else if (s == 1) ins[31:25] = 7'h20;
    return ins;
  endfunction

  initial begin
    compared = 0;
    mismatched = 0;
    i_rst_n = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #3;
    chk_model("reset_before_clock");
    tick();
    model_reset();
    chk_model("reset_held_over_edge");
    i_rst_n = 1'b1;

    // sub
    drive(32'h40208033, 1'b1, 1'b0, 1'b0);
    tick();
    chk("sub.op", o_alu_op, 4'b0001);
    chk("sub.imm", {3'b0, o_alu_src_imm}, 4'd0);
    chk("sub.valid", {3'b0, o_valid}, 4'd1);
    chk_model("sub");

    // srai, blt
    drive(32'h4020D093, 1'b1, 1'b0, 1'b0);
    tick();
    chk("srai.op", o_alu_op, 4'b0111);
    chk("srai.imm", {3'b0, o_alu_src_imm}, 4'd1);
    drive(32'h0020C463, 1'b1, 1'b0, 1'b0);
    tick();
    chk("blt.op", o_alu_op, 4'b0011);
    chk("blt.imm", {3'b0, o_alu_src_imm}, 4'd0);

    // addi then a three-cycle stall with an AND waiting
    drive(32'h00A10113, 1'b1, 1'b0, 1'b0);
    tick();
    chk_model("addi");
    drive(32'h0020F0B3, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.op", o_alu_op, 4'b0000);
      chk("stall.imm", {3'b0, o_alu_src_imm}, 4'd1);
      chk("stall.valid", {3'b0, o_valid}, 4'd1);
    end
    i_stall = 1'b0;
    tick();
    chk("and_release.op", o_alu_op, 4'b1001);
    chk_model("and_release");

    // simultaneous stall and flush
    drive(32'h40208033, 1'b1, 1'b1, 1'b1);
    tick();
    chk("stall_flush.valid", {3'b0, o_valid}, 4'd0);
    chk("stall_flush.op", o_alu_op, 4'b0000);

    // unsupported opcode
    drive(32'h0000007F, 1'b1, 1'b0, 1'b0);
    tick();
`ifdef ALU_OP_DECODER_ILLEGAL_CHECK_EN
    chk("illegal.flag", {3'b0, o_illegal}, 4'd1);
`else
    chk("illegal.flag", {3'b0, o_illegal}, 4'd0);
`endif
    chk("illegal.valid", {3'b0, o_valid}, 4'd1);
    chk("illegal.op", o_alu_op, 4'b0000);

    // asynchronous reset between edges while valid
    drive(32'h4020D093, 1'b1, 1'b0, 1'b0);
    tick();
    chk("pre_async.valid", {3'b0, o_valid}, 4'd1);
    #2;
    i_rst_n = 1'b0;
    model_reset();
    #1;
    chk_model("async_reset");
    #3;
    i_rst_n = 1'b1;

    // reset during a stall discards held state; first edge after release still stalls
    drive(32'h0020F0B3, 1'b1, 1'b0, 1'b0);
    tick();
    i_stall = 1'b1;
    tick();
    chk_model("stall_before_reset");
    i_rst_n = 1'b0;
    model_reset();
    #1;
    chk_model("reset_mid_stall");
    #2;
    i_rst_n = 1'b1;
    tick();
    chk_model("stall_after_reset");
    chk("stall_after_reset.valid", {3'b0, o_valid}, 4'd0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      drive(rand_instr(), ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 2),
            ($urandom_range(0, 15) == 0));
      tick();
      chk_model("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_op_decoder.md
ALU_OP_DECODER -- requirements
Module: alu_op_decoder

Interface
REQ-001 Parameter NB_INSTR, default 32, instruction word width; only 32 is supported.
REQ-002 i_clk  input  1  system clock; all state updates on its rising edge.
REQ-003 i_rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 i_instr  input  NB_INSTR  instruction word from the decode stage.
REQ-005 i_valid  input  1  i_instr holds a real instruction this cycle.
REQ-006 i_stall  input  1  hazard unit stall; hold the registered outputs.
REQ-007 i_flush  input  1  branch/jump flush; insert a bubble.
REQ-008 o_alu_op  output  4  ALU operation code, registered.
REQ-009 o_alu_src_imm  output  1  1 = second ALU operand is the immediate; 0 = rs2; registered.
REQ-010 o_valid  output  1  registered outputs hold a real instruction.
REQ-011 o_illegal  output  1  registered instruction has an unsupported encoding.

Function
REQ-012 ALU op codes SHALL be: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001.
REQ-013 Fields SHALL be: opcode i_instr[6:0], funct3 i_instr[14:12], funct7 i_instr[31:25].
REQ-014 Opcode 0110011 (R-type) SHALL decode from funct3 with o_alu_src_imm=0:
- funct3 000: ADD, or SUB when funct7=0100000.
- funct3 101: SRL, or SRA when funct7=0100000.
- Remaining funct3 values map in the order SLL, SLT, SLTU, XOR, OR, AND.
REQ-015 Opcode 0010011 (I-type ALU) SHALL decode as in REQ-014 with o_alu_src_imm=1, with these differences:
- funct3 000 is always ADD.
- funct3 101 selects SRA when funct7=0100000.
REQ-016 Opcodes 0000011, 0100011, 1100111, 0010111 and 0110111 SHALL produce ADD with o_alu_src_imm=1.
REQ-017 Opcode 1101111 SHALL produce ADD with o_alu_src_imm=1.
REQ-018 Opcode 1100011 (branch) SHALL produce o_alu_src_imm=0 with:
- funct3 000/001: SUB.
- funct3 100/101: SLT.
- funct3 110/111: SLTU.
REQ-019 Latency SHALL be exactly 1 cycle: input sampled at edge N appears on the outputs after edge N.
REQ-020 Edge update priority SHALL be flush > stall > load:
- Flush: o_valid=0, o_alu_op=ADD, o_alu_src_imm=0, o_illegal=0.
- Stall: all outputs hold.
- Load: if i_valid=1, register the decode and set o_valid=1; if i_valid=0, register the flush (bubble) values.
REQ-021 Simultaneous i_flush and i_stall SHALL flush.
REQ-022 A stall lasting any number of cycles SHALL leave outputs bit-identical to their values before the stall.
REQ-023 Decode SHALL be purely combinational ahead of a single register stage, with no other state.

Reset
REQ-024 While i_rst_n=0, outputs SHALL immediately be o_valid=0, o_alu_op=0000, o_alu_src_imm=0, o_illegal=0, regardless of the clock.
REQ-025 Reset asserted mid-stall or mid-flush SHALL discard held state.
REQ-026 After release, the first rising edge SHALL follow REQ-020.

Configuration
REQ-027 With macro ALU_OP_DECODER_ILLEGAL_CHECK_EN defined, o_illegal SHALL be 1 for a registered valid instruction with:
- an opcode not listed in REQ-014..018;
- R-type funct7 other than 0000000, or 0100000 outside funct3 000/101;
- SLLI funct7≠0000000, or SRLI/SRAI funct7 not 0000000/0100000;
- branch funct3 010/011.
Such an instruction SHALL register o_alu_op=ADD with o_valid=1.
REQ-028 Without the macro, o_illegal SHALL be constant 0, and unlisted encodings SHALL decode as ADD with o_alu_src_imm=0, with no extra logic.

Verification
REQ-029 Reset low, then i_valid=1 with i_instr=0x40208033 (sub), one edge -> o_valid=1, o_alu_op=0001, o_alu_src_imm=0.
REQ-030 i_instr=0x4020D093 (srai) -> o_alu_op=0111, o_alu_src_imm=1; i_instr=0x0020C463 (blt) -> 0011, src 0.
REQ-031 Load 0x00A10113 (addi), then i_stall=1 for 3 cycles with i_instr=0x0020F0B3 -> outputs stay ADD/imm/valid; release -> o_alu_op=1001.
REQ-032 i_stall=1 and i_flush=1 on the same edge with valid input -> o_valid=0, o_alu_op=0000.
REQ-033 i_instr=0x0000007F with the macro -> o_illegal=1, o_valid=1, o_alu_op=0000; without the macro -> o_illegal=0.
REQ-034 Assert i_rst_n=0 between clock edges while o_valid=1 -> all outputs 0 before the next edge.
